display_timing_ctrl: RTL and testbench

//  Pixel-clock timing sequencer for the DVI output path. Generates display enable, sync

---
 rtl/display_timing_ctrl_pkg.sv | 30 +++
 rtl/display_timing_ctrl_timing_counter.sv | 40 ++++
 rtl/display_timing_ctrl.sv | 129 ++++++++++++
 tb/tb_display_timing_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/display_timing_ctrl_pkg.sv
// Shared definitions for the DVI pixel timing sequencer: FSM encoding and default
// 640x480@60 timing with derived totals and sync window bounds.
package display_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  // Sync windows are half-open: START <= pos < END.
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  localparam int POS_W = 12;

endpackage

// File: rtl/display_timing_ctrl_timing_counter.sv
// Wrap counter with enable, synchronous clear and terminal-count flag. The next value
// is exported so the parent can register outputs coherent with the counter.
module timing_counter #(
  parameter int WIDTH = 12,
  parameter int MAX   = 799
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o = (count_q == WIDTH'(MAX));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/display_timing_ctrl.sv
// Pixel-clock timing sequencer: IDLE/RUN/DRAIN control with frame-aligned stop, and
// registered DE/sync/strobe outputs computed from the counters' next values.
module display_timing_ctrl
  import display_timing_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic             i_pix_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [1:0]       o_ctrl_ch0,
  output logic [1:0]       o_ctrl_ch1,
  output logic [1:0]       o_ctrl_ch2,
  output logic [POS_W-1:0] o_sx,
  output logic [POS_W-1:0] o_sy,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_running
);

  localparam int X_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int Y_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [POS_W-1:0] X_ACT = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] X_HS0 = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] X_HS1 = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] Y_ACT = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] Y_VS0 = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] Y_VS1 = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  state_e state_q, state_d;

  logic [POS_W-1:0] sx_q, sx_next, sy_q, sy_next;
  logic             x_tc, y_tc, frame_end, counting, cnt_clear;

  logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic line_q, line_d, frame_q, frame_d, running_q, running_d;

  assign counting  = (state_q != ST_IDLE);
  assign cnt_clear = (state_q == ST_IDLE);
  assign frame_end = x_tc & y_tc;

  timing_counter #(.WIDTH(POS_W), .MAX(X_TOTAL - 1)) u_x_cnt (
    .clk_i   (i_pix_clk),
    .rst_i   (i_rst),
    .clear_i (cnt_clear),
    .en_i    (counting),
    .count_o (sx_q),
    .next_o  (sx_next),
    .tc_o    (x_tc)
  );

  timing_counter #(.WIDTH(POS_W), .MAX(Y_TOTAL - 1)) u_y_cnt (
    .clk_i   (i_pix_clk),
    .rst_i   (i_rst),
    .clear_i (cnt_clear),
    .en_i    (counting & x_tc),
    .count_o (sy_q),
    .next_o  (sy_next),
    .tc_o    (y_tc)
  );

  // A low enable sampled on the final pixel stops immediately, from RUN or DRAIN alike.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_enable) state_d = ST_RUN;
      ST_RUN:   if (!i_enable) state_d = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (i_enable)       state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running_d = (state_d != ST_IDLE);
    de_d      = running_d && (sx_next < X_ACT) && (sy_next < Y_ACT);
    hsync_d   = (running_d && (sx_next >= X_HS0) && (sx_next < X_HS1)) ? H_POL : ~H_POL;
    vsync_d   = (running_d && (sy_next >= Y_VS0) && (sy_next < Y_VS1)) ? V_POL : ~V_POL;
    line_d    = running_d && (sx_next == '0);
    frame_d   = line_d && (sy_next == '0);
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      de_q      <= 1'b0;
      hsync_q   <= ~H_POL;
      vsync_q   <= ~V_POL;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
    end
  end

  assign o_de          = de_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_ctrl_ch0    = {vsync_q, hsync_q};
  assign o_ctrl_ch1    = 2'b00;
  assign o_ctrl_ch2    = 2'b00;
  assign o_sx          = sx_q;
  assign o_sy          = sy_q;
  assign o_line_start  = line_q;
  assign o_frame_start = frame_q;
  assign o_running     = running_q;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Directed bench for display_timing_ctrl using a reduced 16x11 raster (8x6 active)
// so whole frames, drains and restarts fit in a short run.
module tb_display_timing_ctrl;

  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;   // 16
  localparam int VT = VA + VFP + VSY + VBP;   // 11

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        de, hs, vs, ls, fs, run;
  logic [1:0]  ch0, ch1, ch2;
  logic [11:0] sx, sy;

  int checks   = 0;
  int failures = 0;
  int mx, my;
  bit mrun;
  int de_cnt, hs_cnt, vs_cnt;

  display_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .i_pix_clk     (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .o_de          (de),
    .o_hsync       (hs),
    .o_vsync       (vs),
    .o_ctrl_ch0    (ch0),
    .o_ctrl_ch1    (ch1),
    .o_ctrl_ch2    (ch2),
    .o_sx          (sx),
    .o_sy          (sy),
    .o_line_start  (ls),
    .o_frame_start (fs),
    .o_running     (run)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at model (%0d,%0d): observed=%0d expected=%0d", tag, mx, my, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs derived from the bench's own raster position model.
  task automatic check_all();
    logic e_de, e_hs, e_vs;
    e_de = mrun && (mx < HA) && (my < VA);
    e_hs = !(mrun && (mx >= HA + HFP) && (mx < HA + HFP + HSY));
    e_vs = !(mrun && (my >= VA + VFP) && (my < VA + VFP + VSY));
    check("sx", 32'(sx), 32'(mx));
    check("sy", 32'(sy), 32'(my));
    check("de", 32'(de), 32'(e_de));
    check("hsync", 32'(hs), 32'(e_hs));
    check("vsync", 32'(vs), 32'(e_vs));
    check("ctrl_ch0", 32'(ch0), 32'({e_vs, e_hs}));
    check("ctrl_ch1", 32'(ch1), 32'd0);
    check("ctrl_ch2", 32'(ch2), 32'd0);
    check("line_start", 32'(ls), 32'(mrun && mx == 0));
    check("frame_start", 32'(fs), 32'(mrun && mx == 0 && my == 0));
    check("running", 32'(run), 32'(mrun));
    if (de) de_cnt++;
    if (!hs) hs_cnt++;
    if (!vs) vs_cnt++;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (mrun) begin
        mx++;
        if (mx == HT) begin
          mx = 0;
          my++;
          if (my == VT) my = 0;
        end
      end
      check_all();
    end
  endtask

  task automatic run_to(input int x, input int y);
    for (int i = 0; i < HT * VT + 2; i++) begin
      if (mx == x && my == y) break;
      adv(1);
    end
  endtask

  task automatic start_frame();
    en = 1'b1;
    tick();
    mrun = 1'b1; mx = 0; my = 0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    mrun = 1'b0; mx = 0; my = 0;
    tick(); tick();
    check_all();                      // reset state
    rst = 1'b0;
    adv(3);                           // IDLE holds without enable

    // Start, then one full frame with aggregate counts
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    start_frame();
    adv(HT * VT - 1);
    check("de_per_frame", 32'(de_cnt), 32'(HA * VA));
    check("hsync_low_per_frame", 32'(hs_cnt), 32'(HSY * VT));
    check("vsync_low_per_frame", 32'(vs_cnt), 32'(VSY * HT));
    adv(1);                           // wrap to (0,0) with frame_start

    // Drop enable mid-frame: frame drains to the last pixel, then IDLE
    run_to(4, 3);
    en = 1'b0;
    run_to(HT - 1, VT - 1);
    tick();
    mrun = 1'b0; mx = 0; my = 0;
    check_all();
    adv(2);

    // Drain, then re-enable exactly on the final pixel: seamless next frame
    start_frame();
    run_to(5, 7);
    en = 1'b0;
    run_to(HT - 1, VT - 1);
    en = 1'b1;
    adv(1);
    // Enable dropped on the final pixel while running: stop right there
    run_to(HT - 1, VT - 1);
    en = 1'b0;
    tick();
    mrun = 1'b0; mx = 0; my = 0;
    check_all();

    // Asynchronous reset mid-frame while hsync is active
    start_frame();
    run_to(11, 2);
    #2 rst = 1'b1;
    #1;
    mrun = 1'b0; mx = 0; my = 0;
    check_all();
    tick();
    check_all();
    rst = 1'b0;
    tick();
    mrun = 1'b1; mx = 0; my = 0;
    check_all();
    adv(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
